// File: rtl/line_fill_unit.sv
// Instruction-cache line fill: on a miss, fetches the aligned line one word at a time
// from instruction memory and presents the complete line with a one-cycle valid pulse.
module line_fill_unit #(
    parameter int LINE_WORDS = 4
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       miss_req,
    input  logic [31:0]                miss_addr,
    output logic                       mem_rd,
    output logic [31:0]                mem_addr,
    input  logic [31:0]                mem_data,
    input  logic                       mem_ack,
    output logic [32*LINE_WORDS-1:0]   dataline,
    output logic [31:0]                line_addr,
    output logic                       line_valid,
    output logic                       busy
);

    localparam int CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF_W     = $clog2(4 * LINE_WORDS);
    localparam int LINE_BITS = 32 * LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [31:0]            base;
    logic [31:0]            line_base;
    logic [LINE_BITS-1:0]   staging;
    logic [LINE_BITS-1:0]   staging_next;
    logic                   accept;
    logic                   take_word;
    logic                   last_word;
    logic                   unused_addr_bits;

    // The fill always starts at word 0, so the byte offset of the miss is dropped.
    assign line_base        = {miss_addr[31:OFF_W], {OFF_W{1'b0}}};
    assign unused_addr_bits = ^miss_addr[OFF_W-1:0];

    assign accept     = (state == IDLE) && miss_req;
    assign take_word  = (state == FILL) && mem_ack;
    assign last_word  = take_word && (cnt == CNT_W'(LINE_WORDS - 1));

    assign mem_rd     = (state == FILL);
    assign line_valid = (state == DONE);
    assign busy       = (state != IDLE);

    always_comb begin
        staging_next = staging;
        if (take_word) begin
            staging_next[32*cnt +: 32] = mem_data;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (miss_req)  state_next = FILL;
            FILL:    if (last_word) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The visible line is only written from the fully assembled staging value,
    // so a partially filled line never reaches dataline.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt       <= '0;
            base      <= '0;
            mem_addr  <= '0;
            staging   <= '0;
            dataline  <= '0;
            line_addr <= '0;
        end else begin
            if (accept) begin
                base     <= line_base;
                mem_addr <= line_base;
                cnt      <= '0;
            end
            if (take_word) begin
                staging <= staging_next;
                if (last_word) begin
                    dataline  <= staging_next;
                    line_addr <= base;
                end else begin
                    cnt      <= cnt + 1'b1;
                    mem_addr <= mem_addr + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_fill_unit.sv
// Directed bench for line_fill_unit with a phase-based reference model checked every cycle.
module tb_line_fill_unit;

    logic         CLK;
    logic         RSTn;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         mem_rd;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_data;
    logic         mem_ack;
    logic [127:0] dataline;
    logic [31:0]  line_addr;
    logic         line_valid;
    logic         busy;

    int           n_checks;
    int           n_fail;
    logic         cmp_on;
    logic [31:0]  dbase;
    logic [31:0]  fixed_data;
    logic         use_fixed;
    logic [31:0]  seen_addr [4];
    int           lat;

    // Memory answers with dbase plus the byte offset of the requested word.
    always_comb mem_data = use_fixed ? fixed_data : dbase + {28'h0, mem_addr[3:0]};

    line_fill_unit #(.LINE_WORDS(4)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack),
        .dataline   (dataline),
        .line_addr  (line_addr),
        .line_valid (line_valid),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: ph 0 = idle, 1..4 = waiting for word ph-1, 5 = line delivered.
    int           ph;
    logic [31:0]  m_base;
    logic [31:0]  m_addr;
    logic [31:0]  m_la;
    logic [127:0] m_dl;
    logic [31:0]  m_w [4];

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ph     <= 0;
            m_base <= '0;
            m_addr <= '0;
            m_la   <= '0;
            m_dl   <= '0;
            for (int i = 0; i < 4; i++) m_w[i] <= '0;
        end else begin
            case (ph)
                0: if (miss_req) begin
                    m_base <= miss_addr & ~32'hF;
                    m_addr <= miss_addr & ~32'hF;
                    ph     <= 1;
                end
                1, 2, 3, 4: if (mem_ack) begin
                    m_w[ph-1] <= mem_data;
                    if (ph == 4) begin
                        m_dl <= {mem_data, m_w[2], m_w[1], m_w[0]};
                        m_la <= m_base;
                        ph   <= 5;
                    end else begin
                        m_addr <= m_base + 32'(4 * ph);
                        ph     <= ph + 1;
                    end
                end
                default: ph <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Issues a miss at a, acks each word after `gap` stall cycles, stops in the DONE cycle.
    task automatic fill(input logic [31:0] a, input logic [31:0] db, input int gap, input bit extra_miss);
        int gc;
        int naddr;
        bit got;
        dbase     = db;
        use_fixed = 1'b0;
        miss_addr = a;
        miss_req  = 1'b1;
        mem_ack   = (gap == 0);
        tick;
        miss_req = 1'b0;
        gc       = 0;
        naddr    = 0;
        got      = 1'b0;
        lat      = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            if (line_valid) begin
                lat      = k + 2;
                got      = 1'b1;
                miss_req = 1'b0;
                mem_ack  = 1'b0;
            end else begin
                if (extra_miss) begin
                    miss_req  = 1'b1;
                    miss_addr = 32'h40;
                end
                if (mem_rd) begin
                    if (gc == gap) begin
                        mem_ack = 1'b1;
                        gc      = 0;
                        if (naddr < 4) seen_addr[naddr] = mem_addr;
                        naddr++;
                    end else begin
                        mem_ack = 1'b0;
                        gc++;
                    end
                end else begin
                    mem_ack = 1'b0;
                end
                tick;
            end
        end
        check("fill_done", got, 1'b1);
        check("words_acked", naddr, 4);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cmp_on     = 1'b0;
        RSTn       = 1'b1;
        miss_req   = 1'b0;
        miss_addr  = '0;
        mem_ack    = 1'b0;
        dbase      = '0;
        fixed_data = '0;
        use_fixed  = 1'b0;
        for (int i = 0; i < 4; i++) seen_addr[i] = '0;

        fork
            forever begin
                @(negedge CLK);
                if (cmp_on) begin
                    check("cyc_mem_rd", mem_rd, (ph >= 1 && ph <= 4));
                    check("cyc_mem_addr", mem_addr, m_addr);
                    check("cyc_line_valid", line_valid, (ph == 5));
                    check("cyc_busy", busy, (ph != 0));
                    check("cyc_dataline", dataline, m_dl);
                    check("cyc_line_addr", line_addr, m_la);
                end
            end
        join_none

        #1 RSTn = 1'b0;
        #1;
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_line_valid", line_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dataline", dataline, 128'h0);
        check("rst_line_addr", line_addr, 32'h0);
        tick;
        tick;
        RSTn   = 1'b1;
        cmp_on = 1'b1;
        tick;

        // Back-to-back acks, unaligned miss address
        fill(32'h14, 32'hA0, 0, 1'b0);
        check("t1_latency", lat, 6);
        check("t1_addr0", seen_addr[0], 32'h10);
        check("t1_addr1", seen_addr[1], 32'h14);
        check("t1_addr2", seen_addr[2], 32'h18);
        check("t1_addr3", seen_addr[3], 32'h1C);
        check("t1_line_addr", line_addr, 32'h10);
        check("t1_dataline", dataline, 128'h000000AC_000000A8_000000A4_000000A0);
        tick;
        check("t1_idle_busy", busy, 1'b0);
        check("t1_idle_valid", line_valid, 1'b0);

        // Two stall cycles before every word
        fill(32'h50, 32'h500, 2, 1'b0);
        check("t2_latency", lat, 14);
        check("t2_addr0", seen_addr[0], 32'h50);
        check("t2_addr3", seen_addr[3], 32'h5C);
        check("t2_line_addr", line_addr, 32'h50);
        check("t2_dataline", dataline, 128'h0000050C_00000508_00000504_00000500);
        tick;
        check("t2_idle_busy", busy, 1'b0);

        // Second miss during a fill must be dropped
        fill(32'h0, 32'h7700, 0, 1'b1);
        check("t3_latency", lat, 6);
        check("t3_addr0", seen_addr[0], 32'h0);
        check("t3_line_addr", line_addr, 32'h0);
        check("t3_dataline", dataline, 128'h0000770C_00007708_00007704_00007700);
        tick;
        check("t3_busy_after_done", busy, 1'b0);
        tick;
        check("t3_not_queued", busy, 1'b0);
        check("t3_no_rd", mem_rd, 1'b0);

        // Reset after two acks abandons the fill
        dbase     = 32'h3300;
        miss_addr = 32'h30;
        miss_req  = 1'b1;
        mem_ack   = 1'b1;
        tick;
        miss_req = 1'b0;
        tick;
        tick;
        check("t4_mid_fill_busy", busy, 1'b1);
        #2 RSTn = 1'b0;
        #1;
        mem_ack = 1'b0;
        check("t4_rst_mem_rd", mem_rd, 1'b0);
        check("t4_rst_mem_addr", mem_addr, 32'h0);
        check("t4_rst_line_valid", line_valid, 1'b0);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_dataline", dataline, 128'h0);
        check("t4_rst_line_addr", line_addr, 32'h0);
        tick;
        check("t4_rst_hold_valid", line_valid, 1'b0);
        tick;
        RSTn = 1'b1;
        tick;
        check("t4_post_rst_dataline", dataline, 128'h0);
        check("t4_post_rst_valid", line_valid, 1'b0);
        fill(32'h20, 32'h2200, 0, 1'b0);
        check("t4_latency", lat, 6);
        check("t4_addr0", seen_addr[0], 32'h20);
        check("t4_line_addr", line_addr, 32'h20);
        check("t4_dataline", dataline, 128'h0000220C_00002208_00002204_00002200);
        tick;

        // Top-of-memory line, no carry out of the line
        fill(32'hFFFF_FFFC, 32'h1000, 0, 1'b0);
        check("t5_addr0", seen_addr[0], 32'hFFFF_FFF0);
        check("t5_addr1", seen_addr[1], 32'hFFFF_FFF4);
        check("t5_addr2", seen_addr[2], 32'hFFFF_FFF8);
        check("t5_addr3", seen_addr[3], 32'hFFFF_FFFC);
        check("t5_line_addr", line_addr, 32'hFFFF_FFF0);
        check("t5_dataline", dataline, 128'h0000100C_00001008_00001004_00001000);
        tick;

        // Stray acks in IDLE
        use_fixed  = 1'b1;
        fixed_data = 32'hDEAD_BEEF;
        mem_ack    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("t6_busy", busy, 1'b0);
            check("t6_valid", line_valid, 1'b0);
            check("t6_mem_rd", mem_rd, 1'b0);
            check("t6_mem_addr", mem_addr, 32'hFFFF_FFFC);
            check("t6_dataline", dataline, 128'h0000100C_00001008_00001004_00001000);
        end
        mem_ack   = 1'b0;
        use_fixed = 1'b0;
        tick;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
